axi_dma_rd_sched: RTL and testbench
===================================

Name: axi_dma_rd_sched

Overview:
- Read-descriptor scheduler in front of the axi_dma read channel.
- Shares the single DMA read descriptor input among N_REQ requesters using round-robin arbitration.
- Limits in-flight descriptors to MAX_OUTSTANDING.
- Stamps each issued tag with the requester index and routes each returned status back to the requester that owns it.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- AXI_ADDR_WIDTH, 16, descriptor address width.
- LEN_WIDTH, 20, descriptor length width.
- TAG_WIDTH, 8, DMA tag width.
- IDX_WIDTH, $clog2(N_REQ), requester-index field width.
- REQ_TAG_WIDTH, TAG_WIDTH-IDX_WIDTH, per-requester tag width.
- MAX_OUTSTANDING, 4, in-flight descriptor limit (1..255).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_req_addr  in  N_REQ*AXI_ADDR_WIDTH  per-requester address; requester i occupies slice i.
- s_req_len  in  N_REQ*LEN_WIDTH  per-requester length.
- s_req_tag  in  N_REQ*REQ_TAG_WIDTH  per-requester tag.
- s_req_valid  in  N_REQ  request valid.
- s_req_ready  out  N_REQ  request accepted, one-hot or zero.
- m_req_status_tag  out  REQ_TAG_WIDTH  returned requester tag.
- m_req_status_error  out  4  returned error code.
- m_req_status_valid  out  N_REQ  one-hot status strobe.
- m_axis_read_desc_addr  out  AXI_ADDR_WIDTH  to DMA.
- m_axis_read_desc_len  out  LEN_WIDTH  to DMA.
- m_axis_read_desc_tag  out  TAG_WIDTH  {index, requester tag}.
- m_axis_read_desc_valid  out  1  descriptor valid.
- m_axis_read_desc_ready  in  1  DMA accepts descriptor.
- s_axis_read_desc_status_tag  in  TAG_WIDTH  status from DMA.
- s_axis_read_desc_status_error  in  4  status error from DMA.
- s_axis_read_desc_status_valid  in  1  status strobe from DMA.
- enable  in  1  permit new grants.
- outstanding  out  8  in-flight descriptor count.
- bad_status  out  1  one-cycle pulse on an unroutable or unexpected status.

Behaviour:
- Reset values: every output is 0; outstanding is 0; round-robin pointer last_grant = N_REQ-1, so requester 0 has first priority.
- Output stage is a single register slot (out_full).
- Grant condition: enable=1, out_full=0, outstanding < MAX_OUTSTANDING, and some s_req_valid=1.
  - Winner g is the first valid requester found searching from last_grant+1 upward, wrapping modulo N_REQ.
  - s_req_ready[g]=1 combinationally in that cycle; the request handshake completes that cycle.
  - The slot loads addr/len of g and tag={g[IDX_WIDTH-1:0], s_req_tag slice g}.
  - out_full←1 and last_grant←g.
- Latency: grant in cycle N gives m_axis_read_desc_valid=1 from cycle N+1.
- Output handshake:
  - valid and data are held stable until m_axis_read_desc_ready=1.
  - On that handshake out_full←0 and outstanding increments.
  - No grant happens in the cycle the slot empties, so peak throughput is 1 descriptor per 2 cycles. There is no combinational path from m_axis_read_desc_ready to s_req_ready.
- Credit: outstanding counts descriptors accepted by the DMA whose status has not yet returned. The held descriptor is not counted, but no grant occurs while out_full=1, so in-flight plus held never exceeds MAX_OUTSTANDING.
- Status routing: s_axis_read_desc_status_valid with tag index k, taken from the upper IDX_WIDTH bits.
  - If k < N_REQ: registered one cycle, then m_req_status_valid[k]=1 for exactly one cycle, with m_req_status_tag = lower REQ_TAG_WIDTH bits and m_req_status_error passed through. Status outputs are a pure registered copy, with no backpressure.
  - If k >= N_REQ: the status is dropped and bad_status pulses one cycle later.
  - Status is accepted and routed even when enable=0.
- Counter update:
  - Increment on descriptor handshake; decrement on a status strobe.
  - Both in the same cycle leaves it unchanged.
  - A decrement at 0 saturates at 0 and pulses bad_status.
- enable=0 blocks new grants only. A held descriptor stays valid until accepted, and status routing continues.
- A requester dropping s_req_valid without being granted is legal; it is simply skipped.
- Zero-length descriptors are passed through unchanged, and the DMA returns status for them.
- Reset asserted mid-operation: all state clears immediately, a held descriptor is discarded and outstanding returns to 0. Late status from the DMA after reset decrements at 0 and pulses bad_status.

Test Plan:
- Single request: requester 2 issues addr=0x0100, len=64, tag=0x05, DMA ready=1 → m_axis_read_desc_valid one cycle after grant, tag=0x85 (IDX_WIDTH=2), outstanding 0→1. Status tag=0x85, err=0 → m_req_status_valid=4'b0100, tag=0x05 one cycle later, outstanding→0.
- Round-robin: all 4 requesters valid continuously, DMA always ready, status returned immediately → grant order 0,1,2,3,0,1…; no requester granted twice before all others are granted once.
- Credit limit: MAX_OUTSTANDING=4, no status returned → exactly 4 descriptors issued; all s_req_ready stay 0 afterwards. One status returns → exactly one more grant.
- Backpressure: DMA ready=0 for 10 cycles → descriptor held stable with valid=1 and no new s_req_ready. Ready=1 → handshake, then next grant follows after one idle cycle.
- Simultaneous events and bad tag: descriptor handshake and status in the same cycle → outstanding unchanged. Status tag=0xC0 with N_REQ=3 → no m_req_status_valid and one bad_status pulse.
- Enable/reset: enable=0 with requests pending → no grants while status still routes. rst_n low while a descriptor is held → valid=0 and outstanding=0 immediately; after release, requester 0 wins first.

Source files
------------

// File: rtl/axi_dma_rd_sched.sv
// Round-robin read-descriptor scheduler: N_REQ requesters share one DMA read
// descriptor port under an in-flight credit limit, and status is routed back by tag index.
module axi_dma_rd_sched #(
  parameter int N_REQ           = 4,
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 20,
  parameter int TAG_WIDTH       = 8,
  parameter int IDX_WIDTH       = $clog2(N_REQ),
  parameter int REQ_TAG_WIDTH   = TAG_WIDTH - IDX_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]   s_req_addr,
  input  logic [N_REQ*LEN_WIDTH-1:0]        s_req_len,
  input  logic [N_REQ*REQ_TAG_WIDTH-1:0]    s_req_tag,
  input  logic [N_REQ-1:0]                  s_req_valid,
  output logic [N_REQ-1:0]                  s_req_ready,
  output logic [REQ_TAG_WIDTH-1:0]          m_req_status_tag,
  output logic [3:0]                        m_req_status_error,
  output logic [N_REQ-1:0]                  m_req_status_valid,
  output logic [AXI_ADDR_WIDTH-1:0]         m_axis_read_desc_addr,
  output logic [LEN_WIDTH-1:0]              m_axis_read_desc_len,
  output logic [TAG_WIDTH-1:0]              m_axis_read_desc_tag,
  output logic                              m_axis_read_desc_valid,
  input  logic                              m_axis_read_desc_ready,
  input  logic [TAG_WIDTH-1:0]              s_axis_read_desc_status_tag,
  input  logic [3:0]                        s_axis_read_desc_status_error,
  input  logic                              s_axis_read_desc_status_valid,
  input  logic                              enable,
  output logic [7:0]                        outstanding,
  output logic                              bad_status
);

  logic                      out_full_q, out_full_d;
  logic [AXI_ADDR_WIDTH-1:0] desc_addr_q, desc_addr_d;
  logic [LEN_WIDTH-1:0]      desc_len_q, desc_len_d;
  logic [TAG_WIDTH-1:0]      desc_tag_q, desc_tag_d;
  logic [IDX_WIDTH-1:0]      last_grant_q, last_grant_d;
  logic [7:0]                outstanding_q, outstanding_d;
  logic [N_REQ-1:0]          st_valid_q, st_valid_d;
  logic [REQ_TAG_WIDTH-1:0]  st_tag_q, st_tag_d;
  logic [3:0]                st_err_q, st_err_d;
  logic                      bad_status_q, bad_status_d;

  logic                      found;
  logic [IDX_WIDTH-1:0]      winner;
  logic                      grant;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]      sel_len;
  logic [REQ_TAG_WIDTH-1:0]  sel_tag;
  logic                      desc_hs;
  logic [IDX_WIDTH-1:0]      st_idx;
  logic                      st_ok;

  // Two ordered passes give the search from last_grant+1 with wraparound.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && s_req_valid[i] && (IDX_WIDTH'(i) > last_grant_q)) begin
        found  = 1'b1;
        winner = IDX_WIDTH'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && s_req_valid[i] && (IDX_WIDTH'(i) <= last_grant_q)) begin
        found  = 1'b1;
        winner = IDX_WIDTH'(i);
      end
    end
  end

  assign grant = enable && !out_full_q && (outstanding_q < 8'(MAX_OUTSTANDING)) && found;

  always_comb begin
    sel_addr    = '0;
    sel_len     = '0;
    sel_tag     = '0;
    s_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDX_WIDTH'(i)) begin
        sel_addr       = s_req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        sel_len        = s_req_len[i*LEN_WIDTH +: LEN_WIDTH];
        sel_tag        = s_req_tag[i*REQ_TAG_WIDTH +: REQ_TAG_WIDTH];
        s_req_ready[i] = grant;
      end
    end
  end

  assign desc_hs = out_full_q && m_axis_read_desc_ready;
  assign st_idx  = s_axis_read_desc_status_tag[TAG_WIDTH-1 -: IDX_WIDTH];
  assign st_ok   = int'(st_idx) < N_REQ;

  always_comb begin
    out_full_d   = out_full_q;
    desc_addr_d  = desc_addr_q;
    desc_len_d   = desc_len_q;
    desc_tag_d   = desc_tag_q;
    last_grant_d = last_grant_q;
    // Grant and slot-empty are exclusive: a grant needs an empty slot.
    if (grant) begin
      out_full_d   = 1'b1;
      desc_addr_d  = sel_addr;
      desc_len_d   = sel_len;
      desc_tag_d   = {winner, sel_tag};
      last_grant_d = winner;
    end else if (desc_hs) begin
      out_full_d = 1'b0;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    bad_status_d  = 1'b0;
    if (desc_hs && !s_axis_read_desc_status_valid) begin
      outstanding_d = outstanding_q + 8'd1;
    end else if (s_axis_read_desc_status_valid && !desc_hs) begin
      if (outstanding_q == 8'd0) begin
        bad_status_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q - 8'd1;
      end
    end
    if (s_axis_read_desc_status_valid && !st_ok) begin
      bad_status_d = 1'b1;
    end
  end

  always_comb begin
    st_valid_d = '0;
    st_tag_d   = s_axis_read_desc_status_tag[REQ_TAG_WIDTH-1:0];
    st_err_d   = s_axis_read_desc_status_error;
    for (int i = 0; i < N_REQ; i++) begin
      st_valid_d[i] = s_axis_read_desc_status_valid && st_ok && (st_idx == IDX_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_full_q    <= 1'b0;
      desc_addr_q   <= '0;
      desc_len_q    <= '0;
      desc_tag_q    <= '0;
      last_grant_q  <= IDX_WIDTH'(N_REQ - 1);
      outstanding_q <= 8'd0;
      st_valid_q    <= '0;
      st_tag_q      <= '0;
      st_err_q      <= 4'd0;
      bad_status_q  <= 1'b0;
    end else begin
      out_full_q    <= out_full_d;
      desc_addr_q   <= desc_addr_d;
      desc_len_q    <= desc_len_d;
      desc_tag_q    <= desc_tag_d;
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      st_valid_q    <= st_valid_d;
      st_tag_q      <= st_tag_d;
      st_err_q      <= st_err_d;
      bad_status_q  <= bad_status_d;
    end
  end

  assign m_axis_read_desc_valid = out_full_q;
  assign m_axis_read_desc_addr  = desc_addr_q;
  assign m_axis_read_desc_len   = desc_len_q;
  assign m_axis_read_desc_tag   = desc_tag_q;
  assign m_req_status_valid     = st_valid_q;
  assign m_req_status_tag       = st_tag_q;
  assign m_req_status_error     = st_err_q;
  assign outstanding            = outstanding_q;
  assign bad_status             = bad_status_q;

endmodule

// File: tb/tb_axi_dma_rd_sched.sv
// Bench for axi_dma_rd_sched (N_REQ=3 so unroutable tag indices exist): directed
// scenarios plus randomized traffic, all checked against a cycle-level reference model.
module tb_axi_dma_rd_sched;
  localparam int N = 3, AW = 16, LW = 20, TW = 8, IW = 2, RTW = 6, MAXO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*AW-1:0]  s_req_addr;
  logic [N*LW-1:0]  s_req_len;
  logic [N*RTW-1:0] s_req_tag;
  logic [N-1:0]     s_req_valid;
  logic [N-1:0]     s_req_ready;
  logic [RTW-1:0]   m_req_status_tag;
  logic [3:0]       m_req_status_error;
  logic [N-1:0]     m_req_status_valid;
  logic [AW-1:0]    m_axis_read_desc_addr;
  logic [LW-1:0]    m_axis_read_desc_len;
  logic [TW-1:0]    m_axis_read_desc_tag;
  logic             m_axis_read_desc_valid;
  logic             m_axis_read_desc_ready = 1'b0;
  logic [TW-1:0]    st_tag_in = '0;
  logic [3:0]       st_err_in = '0;
  logic             st_v_in = 1'b0;
  logic             enable = 1'b0;
  logic [7:0]       outstanding;
  logic             bad_status;

  logic [AW-1:0]  rq_addr [N];
  logic [LW-1:0]  rq_len  [N];
  logic [RTW-1:0] rq_tag  [N];
  logic           rq_v    [N];

  always_comb begin
    s_req_addr = '0; s_req_len = '0; s_req_tag = '0; s_req_valid = '0;
    for (int i = 0; i < N; i++) begin
      s_req_addr[i*AW +: AW]   = rq_addr[i];
      s_req_len[i*LW +: LW]    = rq_len[i];
      s_req_tag[i*RTW +: RTW]  = rq_tag[i];
      s_req_valid[i]           = rq_v[i];
    end
  end

  axi_dma_rd_sched #(
    .N_REQ(N), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
    .IDX_WIDTH(IW), .REQ_TAG_WIDTH(RTW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_addr(s_req_addr), .s_req_len(s_req_len), .s_req_tag(s_req_tag),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .m_req_status_tag(m_req_status_tag), .m_req_status_error(m_req_status_error),
    .m_req_status_valid(m_req_status_valid),
    .m_axis_read_desc_addr(m_axis_read_desc_addr), .m_axis_read_desc_len(m_axis_read_desc_len),
    .m_axis_read_desc_tag(m_axis_read_desc_tag), .m_axis_read_desc_valid(m_axis_read_desc_valid),
    .m_axis_read_desc_ready(m_axis_read_desc_ready),
    .s_axis_read_desc_status_tag(st_tag_in), .s_axis_read_desc_status_error(st_err_in),
    .s_axis_read_desc_status_valid(st_v_in),
    .enable(enable), .outstanding(outstanding), .bad_status(bad_status)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state: what the outputs must show after the most recent edge.
  int          m_last;
  bit          m_full;
  logic [AW-1:0]  m_addr;
  logic [LW-1:0]  m_len;
  logic [TW-1:0]  m_tag;
  int          m_cnt;
  logic [N-1:0]   m_stv;
  logic [RTW-1:0] m_sttag;
  logic [3:0]     m_sterr;
  bit          m_bad;
  logic [TW-1:0] inflight[$];
  int          grants[$];
  int          last_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1; m_full = 0; m_addr = '0; m_len = '0; m_tag = '0;
    m_cnt = 0; m_stv = '0; m_sttag = '0; m_sterr = '0; m_bad = 0; last_w = -1;
  endtask

  function automatic int model_winner();
    if (!enable || m_full || m_cnt >= MAXO) return -1;
    for (int i = 1; i <= N; i++) begin
      if (rq_v[(m_last + i) % N]) return (m_last + i) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input int w);
    bit hs, sv;
    int k;
    hs = m_full && m_axis_read_desc_ready;
    sv = st_v_in;
    k  = int'(st_tag_in[TW-1 -: IW]);
    m_bad   = sv && (k >= N || (!hs && m_cnt == 0));
    m_stv   = (sv && k < N) ? N'(1 << k) : '0;
    m_sttag = st_tag_in[RTW-1:0];
    m_sterr = st_err_in;
    if (hs) begin
      inflight.push_back(m_tag);
      m_full = 0;
    end
    if (hs && !sv) m_cnt++;
    else if (sv && !hs && m_cnt > 0) m_cnt--;
    if (w >= 0) begin
      m_full = 1;
      m_addr = rq_addr[w];
      m_len  = rq_len[w];
      m_tag  = TW'(w << RTW) | TW'(rq_tag[w]);
      m_last = w;
      grants.push_back(w);
    end
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic cycle();
    int w;
    #1;
    w = model_winner();
    last_w = w;
    chk("s_req_ready", 32'(s_req_ready), (w >= 0) ? 32'(1 << w) : 32'd0);
    chk("desc_valid", 32'(m_axis_read_desc_valid), 32'(m_full));
    if (m_full) begin
      chk("desc_addr", 32'(m_axis_read_desc_addr), 32'(m_addr));
      chk("desc_len", 32'(m_axis_read_desc_len), 32'(m_len));
      chk("desc_tag", 32'(m_axis_read_desc_tag), 32'(m_tag));
    end
    chk("outstanding", 32'(outstanding), 32'(m_cnt));
    chk("status_valid", 32'(m_req_status_valid), 32'(m_stv));
    if (m_stv != '0) begin
      chk("status_tag", 32'(m_req_status_tag), 32'(m_sttag));
      chk("status_err", 32'(m_req_status_error), 32'(m_sterr));
    end
    chk("bad_status", 32'(bad_status), 32'(m_bad));
    @(posedge clk);
    model_step(w);
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) rq_v[i] = 1'b0;
    st_v_in = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_desc_valid", 32'(m_axis_read_desc_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_status_valid", 32'(m_req_status_valid), 32'd0);
    chk("rst_bad_status", 32'(bad_status), 32'd0);
    chk("rst_ready", 32'(s_req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_req(input int i);
    rq_addr[i] = AW'($urandom);
    rq_len[i]  = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom);
    rq_tag[i]  = RTW'($urandom);
  endtask

  task automatic all_valid(input logic v);
    for (int i = 0; i < N; i++) rq_v[i] = v;
  endtask

  task automatic status_front();
    st_tag_in = inflight.pop_front();
    st_err_in = 4'($urandom);
    st_v_in   = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    for (int i = 0; i < N; i++) begin rand_req(i); rq_v[i] = 1'b0; end
    model_reset();
    @(negedge clk);
    do_reset();

    // Single request from requester 2.
    enable = 1'b1;
    m_axis_read_desc_ready = 1'b1;
    rq_addr[2] = 16'h0100; rq_len[2] = 20'd64; rq_tag[2] = 6'h05; rq_v[2] = 1'b1;
    cycle();
    chk("single_valid", 32'(m_axis_read_desc_valid), 32'd1);
    chk("single_tag", 32'(m_axis_read_desc_tag), 32'h85);
    chk("single_addr", 32'(m_axis_read_desc_addr), 32'h0100);
    chk("single_len", 32'(m_axis_read_desc_len), 32'd64);
    rq_v[2] = 1'b0;
    cycle();
    chk("single_outstanding1", 32'(outstanding), 32'd1);
    st_tag_in = 8'h85; st_err_in = 4'd0; st_v_in = 1'b1;
    void'(inflight.pop_front());
    cycle();
    st_v_in = 1'b0;
    chk("single_st_valid", 32'(m_req_status_valid), 32'b100);
    chk("single_st_tag", 32'(m_req_status_tag), 32'h05);
    chk("single_outstanding0", 32'(outstanding), 32'd0);

    // Credit limit with round-robin order.
    all_valid(1'b1);
    g0 = grants.size();
    for (int c = 0; c < 12; c++) cycle();
    chk("credit_grants", 32'(grants.size() - g0), 32'd4);
    chk("rr_order0", 32'(grants[g0]), 32'd0);
    chk("rr_order1", 32'(grants[g0+1]), 32'd1);
    chk("rr_order2", 32'(grants[g0+2]), 32'd2);
    chk("rr_order3", 32'(grants[g0+3]), 32'd0);
    chk("credit_outstanding", 32'(outstanding), 32'd4);
    chk("credit_ready", 32'(s_req_ready), 32'd0);
    status_front();
    cycle();
    st_v_in = 1'b0;
    chk("credit_route", 32'(m_req_status_valid), 32'b001);
    for (int c = 0; c < 6; c++) cycle();
    chk("credit_one_more", 32'(grants.size() - g0), 32'd5);
    chk("credit_next_winner", 32'(grants[$]), 32'd1);

    // Drain, then backpressure.
    all_valid(1'b0);
    for (int t = 0; t < 50 && inflight.size() > 0; t++) begin
      status_front();
      cycle();
    end
    st_v_in = 1'b0;
    cycle();
    chk("drain_outstanding", 32'(outstanding), 32'd0);
    m_axis_read_desc_ready = 1'b0;
    all_valid(1'b1);
    g0 = grants.size();
    for (int c = 0; c < 10; c++) cycle();
    chk("bp_one_grant", 32'(grants.size() - g0), 32'd1);
    chk("bp_held_valid", 32'(m_axis_read_desc_valid), 32'd1);
    m_axis_read_desc_ready = 1'b1;
    cycle();
    chk("bp_no_grant_on_empty", 32'(grants.size() - g0), 32'd1);
    cycle();
    chk("bp_next_grant", 32'(grants.size() - g0), 32'd2);
    chk("bp_next_winner", 32'(grants[$]), 32'd0);

    // Handshake and status in the same cycle, then an unroutable tag.
    all_valid(1'b0);
    status_front();
    cycle();
    chk("simul_outstanding", 32'(outstanding), 32'd1);
    m_axis_read_desc_ready = 1'b0;
    st_tag_in = 8'hC0; st_v_in = 1'b1;
    cycle();
    st_v_in = 1'b0;
    chk("badtag_pulse", 32'(bad_status), 32'd1);
    chk("badtag_no_route", 32'(m_req_status_valid), 32'd0);
    cycle();
    chk("badtag_single_pulse", 32'(bad_status), 32'd0);

    // enable=0 blocks grants while status still routes.
    enable = 1'b0;
    all_valid(1'b1);
    g0 = grants.size();
    st_tag_in = 8'h6A; st_err_in = 4'd9; st_v_in = 1'b1;
    cycle();
    st_v_in = 1'b0;
    chk("dis_route", 32'(m_req_status_valid), 32'b010);
    chk("dis_err", 32'(m_req_status_error), 32'd9);
    for (int c = 0; c < 4; c++) cycle();
    chk("dis_no_grant", 32'(grants.size() - g0), 32'd0);

    // Reset while a descriptor is held and one is outstanding.
    enable = 1'b1;
    m_axis_read_desc_ready = 1'b1;
    cycle();
    cycle();
    m_axis_read_desc_ready = 1'b0;
    cycle();
    cycle();
    chk("pre_rst_valid", 32'(m_axis_read_desc_valid), 32'd1);
    chk("pre_rst_outstanding", 32'(outstanding), 32'd1);
    do_reset();
    all_valid(1'b1);
    m_axis_read_desc_ready = 1'b1;
    st_tag_in = 8'h05; st_v_in = 1'b1;
    cycle();
    st_v_in = 1'b0;
    chk("post_rst_winner", 32'(grants[$]), 32'd0);
    chk("late_status_bad", 32'(bad_status), 32'd1);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      int r;
      for (int i = 0; i < N; i++) begin
        if (last_w == i || $urandom_range(0, 7) == 0) begin
          rand_req(i);
          rq_v[i] = ($urandom_range(0, 3) != 0);
        end
      end
      enable = ($urandom_range(0, 15) != 0);
      m_axis_read_desc_ready = ($urandom_range(0, 9) < 7);
      st_v_in = 1'b0;
      st_err_in = 4'($urandom);
      r = $urandom_range(0, 49);
      if (inflight.size() > 0 && r < 20) begin
        int j;
        j = $urandom_range(0, inflight.size() - 1);
        st_tag_in = inflight[j];
        inflight.delete(j);
        st_v_in = 1'b1;
      end else if (r == 49) begin
        st_tag_in = {2'b11, 6'($urandom)};
        st_v_in = 1'b1;
      end else if (r == 48) begin
        st_tag_in = {2'($urandom_range(0, 2)), 6'($urandom)};
        st_v_in = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
